serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial addition controller that drives one `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands. The block owns the operand shift registers, the carry flip-flop, the bit counter and the result registers. It sits between a requester and the shared one-bit adder cell, trading latency for area. A start/done/ack handshake launches each operation and returns its result.

## Interface
- `WIDTH`, default 8, operand and result width in bits (legal range 2..32).
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `rst`  input  1  synchronous, active-high reset, sampled on rising `clk`.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  operand A; captured when `start` is accepted.
- `b`  input  WIDTH  operand B; captured when `start` is accepted.
- `cin`  input  1  carry-in; captured when `start` is accepted.
- `ack`  input  1  result consumed; sampled only in DONE.
- `busy`  output  1  high whenever state is not IDLE.
- `done`  output  1  high in DONE; `sum`, `cout` and `ovf` are valid while high.
- `sum`  output  WIDTH  result register.
- `cout`  output  1  carry out of the MSB.
- `ovf`  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Datapath:
  - One `full_adder` instance with inputs `a`=A_sr[0], `b`=B_sr[0], `cin`=carry_ff.
  - A_sr and B_sr shift right each RUN cycle.
  - Adder `s` shifts into the MSB of the partial-sum shift register (LSB-first accumulation).
  - carry_ff <= adder `cout` each RUN cycle.
- Counter: 5-bit `cnt`, cleared on start acceptance, incremented each RUN cycle.
- FSM states: IDLE, RUN, DONE. Encoding is free; no other reachable states.
- IDLE, `start`=1: load A_sr<=a, B_sr<=b, carry_ff<=cin, cnt<=0; go to RUN.
- IDLE, `start`=0: hold all state.
- RUN: one bit per cycle. When `cnt`==WIDTH-1, the bit in progress is the MSB.
  - Record carry_ff as carry-into-MSB.
  - Load `sum`<=final partial sum (including this bit's `s`), `cout`<=adder `cout`, `ovf`<=carry-into-MSB XOR adder `cout`.
  - Go to DONE.
- DONE, `ack`=1: go to IDLE. `sum`, `cout` and `ovf` keep their values until the next DONE entry.
- DONE, `ack`=0: hold indefinitely; `done` stays high.
- `start` outside IDLE is ignored, including in the same cycle as `ack` in DONE. The requester must re-assert `start` after `busy` falls.
- `ack` outside DONE is ignored.
- Operand inputs are don't-care except in the cycle where `start` is accepted.
- Arithmetic: result is modulo 2^WIDTH, and {`cout`,`sum`} == a+b+cin exactly.
- `sum`, `cout` and `ovf` never show partial values; they change only on DONE entry and on reset.

## Timing
- Reset (edge where `rst`=1): state=IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - A_sr, B_sr, carry_ff and cnt cleared.
  - Reset overrides `start` and `ack` on the same edge.
  - Reset during RUN or DONE aborts the operation with no result delivered.
- Edge E0 samples `start`=1 in IDLE. `busy`=1 from just after E0.
- RUN occupies WIDTH cycles, edges E1..E(WIDTH).
- `done`=1 and results are valid from just after E(WIDTH): latency WIDTH+1 edges from start to done.
- If `ack`=1 at edge Ek in DONE, then `done`=0 and `busy`=0 just after Ek.
- Earliest next start acceptance is at edge Ek+1. Maximum throughput is one add per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start at E0 -> `done` rises after E8; `sum`=0x96, `cout`=0, `ovf`=1.
- a=0xFF, b=0x01, cin=0 -> `sum`=0x00, `cout`=1, `ovf`=0. Then a=0x00, b=0x00, cin=1 -> `sum`=0x01, `cout`=0, `ovf`=0.
- a=0x80, b=0x80, cin=0 -> `sum`=0x00, `cout`=1, `ovf`=1. Hold `ack`=0 for 5 cycles -> `done` and `sum` stable throughout. `ack`=1 -> `done`=0 and `busy`=0 next cycle.
- Pulse `start` with a=0x11, b=0x22 on the 3rd RUN cycle of an a=0x01, b=0x02 add -> second request ignored. Result `sum`=0x03, then IDLE after `ack`.
- Assert `rst` on the 4th RUN cycle -> next cycle: IDLE, all outputs 0, no `done` pulse. A fresh start then completes correctly.
- Random sweep of 1000 operands with `ack` delayed randomly by 0..3 cycles -> {`cout`,`sum`} == a+b+cin every time. `start` in the `ack` cycle is never accepted.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. One shared full_adder cell is stepped over
//   WIDTH clock cycles, LSB first, to add two WIDTH-bit operands plus a
//   carry-in. A start/done/ack handshake launches each add and returns the
//   result.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE (captures a, b, cin)
//   a, b   WIDTH-bit operands
//   cin    carry-in
//   ack    result consumed, sampled only in DONE
//   busy   high whenever not IDLE
//   done   high in DONE; sum/cout/ovf valid
//   sum    WIDTH-bit result register
//   cout   carry out of the MSB
//   ovf    signed overflow (carry into MSB xor carry out of MSB)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry_ff;
  logic [4:0]       cnt;
  logic             load;
  logic             last_bit;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_ff),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode. load marks start acceptance; last_bit marks the
  // cycle where the adder is working on the MSB.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done decode the state register directly, so they are registered
  // values with no path from any input.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Datapath. The partial sum fills from the MSB end so that after WIDTH
  // shifts bit 0 of the result sits in psum[0]. The visible result is only
  // written on the MSB cycle, so sum/cout/ovf never expose partial values.
  // carry_ff on the MSB cycle is the carry into the MSB, which gives ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      psum     <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (load) begin
      a_sr     <= a;
      b_sr     <= b;
      carry_ff <= cin;
      cnt      <= '0;
      psum     <= '0;
    end else if (state == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      carry_ff <= fa_cout;
      cnt      <= cnt + 5'd1;
      psum     <= {fa_s, psum[WIDTH-1:1]};
      if (last_bit) begin
        sum  <= {fa_s, psum[WIDTH-1:1]};
        cout <= fa_cout;
        ovf  <= carry_ff ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed bench for serial_add_ctrl at WIDTH=8: reset state, directed
//   adds with hand-computed results, ack hold, ignored start in RUN and in
//   the ack cycle, reset abort, and an operand sweep against a+b+cin.

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ack   (ack),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    tests++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_state got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  // Full transaction: start, check exact latency and result, hold ack for
  // ack_delay cycles, then ack with start raised in the same cycle.
  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec,
                        input logic eo, input int ack_delay);
    int n;
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0; a = ~av; b = ~bv; cin = ~cv;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s_busy got %b want 1", name, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (n !== WIDTH) begin
      fails++;
      $display("[TB] FAIL %s_latency got %0d edges want %0d", name, n, WIDTH);
    end
    tests++;
    if ({cout, sum, ovf} !== {ec, es, eo}) begin
      fails++;
      $display("[TB] FAIL %s_result got cout=%b sum=%h ovf=%b want cout=%b sum=%h ovf=%b",
               name, cout, sum, ovf, ec, es, eo);
    end
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      tests++;
      if ({done, sum} !== {1'b1, es}) begin
        fails++;
        $display("[TB] FAIL %s_hold got done=%b sum=%h want done=1 sum=%h", name, done, sum, es);
      end
    end
    ack = 1'b1; start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b0;
    tests++;
    if ({busy, done, sum} !== {1'b0, 1'b0, es}) begin
      fails++;
      $display("[TB] FAIL %s_ack got busy=%b done=%b sum=%h want busy=0 done=0 sum=%h",
               name, busy, done, sum, es);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_start_in_ack got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_directed();
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    run_op("add_cin",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 2);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("add_aa_55", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 3);
  endtask

  task automatic test_ack_hold();
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 5);
  endtask

  // Second start pulsed before the third RUN edge must be ignored.
  task automatic test_start_in_run();
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'h11; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if ({done, sum, cout, ovf} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL start_in_run got done=%b sum=%h cout=%b ovf=%b want done=1 sum=03 cout=0 ovf=0",
               done, sum, cout, ovf);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL start_in_run_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  // Reset asserted for the fourth RUN edge aborts the add.
  task automatic test_reset_abort();
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_abort got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_abort_no_done got done=%b want 0", done);
      end
    end
    run_op("after_reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);
  endtask

  task automatic test_sweep();
    logic [7:0] av, bv, es;
    logic       cv, ec, eo;
    logic [8:0] full;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      cv = 1'($urandom);
      full = {1'b0, av} + {1'b0, bv} + {8'h00, cv};
      es = full[7:0];
      ec = full[8];
      eo = (av[7] == bv[7]) && (es[7] != av[7]);
      run_op("sweep", av, bv, cv, es, ec, eo, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ack_hold();
    test_start_in_run();
    test_reset_abort();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
